dot_product_scheduler: RTL
==========================

Name: dot_product_scheduler

Overview:
Round-robin job scheduler that shares one serial 16-bit multiply-accumulate engine between NREQ requesters. Each requester submits one 8-element x 16-bit inner-product job over a valid/ready handshake. The block captures the operands, sequences the 8 MAC steps and returns a 36-bit result tagged with the requester ID over a valid/ready result port. It sits between the vector producers and the result consumer, in place of instantiating one engine per requester.

Parameters:
NREQ, 4, number of requesters (2..8)
ELEMS, 8, elements per vector
EW, 16, element width in bits
ACCW, 36, accumulator and result width
IDW, 2, requester ID width, equal to clog2(NREQ)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  per-requester job valid
req_ready  out  NREQ  per-requester accept, at most one bit high
req_a  in  NREQ*ELEMS*EW  operand A vectors; requester r occupies [r*128 +: 128]
req_b  in  NREQ*ELEMS*EW  operand B vectors, same packing as req_a
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  ACCW  inner product
res_id  out  IDW  requester that issued the job
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, res_valid=0, res_data=0, res_id=0, busy=0, req_ready=0, round-robin pointer=0, accumulator=0, step counter=0.
- Element i of a vector is bits [i*EW +: EW]. Operands are unsigned.
- Each product is 32 bits. Products are zero-extended and summed into ACCW bits. The maximum sum is 8*(2^16-1)^2 < 2^35, so overflow cannot occur.
- IDLE state:
  - req_ready is combinational. It is one-hot for the first asserted req_valid, searching from the pointer upward with wrap-around.
  - req_ready is all-zero if no req_valid is high, and all-zero in every other state.
  - Handshake: req_valid[r] and req_ready[r] both high at a rising edge.
  - On handshake: capture req_a and req_b slices of r into internal operand registers, latch r as the ID, clear the accumulator, set the counter to 0, and set the pointer to (r+1) mod NREQ. Go to RUN.
- RUN state:
  - Each edge adds A[k]*B[k] to the accumulator and increments k.
  - When k=ELEMS-1 at an edge, the final sum loads res_data, res_valid is set to 1, and the state goes to DONE.
  - Latency: res_valid is high exactly ELEMS (8) edges after the acceptance edge.
- DONE state:
  - res_valid, res_data and res_id are held stable until res_ready is high at an edge. Then res_valid goes to 0 and the state goes to IDLE.
  - res_data and res_id keep their last values after the transfer.
  - No new job is accepted while in DONE.
- Throughput: 1 job per 10 cycles with res_ready held high.
- Input independence: requester inputs may change after acceptance without affecting the running job.
- Withdrawal: a requester that drops req_valid before a grant simply loses its turn. The pointer is not changed.
- Reset mid-operation: the job is abandoned, no result is emitted, and all registers return to their reset values.
- Pointer after wrap: a grant to NREQ-1 sets the pointer to 0.

Decomposition:
- Shared package dp_pkg holds the constants ELEMS, EW and ACCW and a state enum: IDLE, RUN, DONE.
- Sub-module rr_arbiter, parameter NREQ:
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and binary grant index.
  - Purely combinational. The pointer register stays in the scheduler.

Test Plan:
- Single job: requester 0 sends a = elements 1..8, b = all 2; res_ready held high -> req_ready[0] high for one cycle; res_valid high 8 edges later; res_data=72, res_id=0, then busy=0.
- Max operands: requester 2 sends all elements 0xFFFF in a and b -> res_data=0x7FFF00008, res_id=2.
- Round-robin fairness: all 4 req_valid held high, distinct operands per requester -> grant order 0,1,2,3,0; each res_data matches its own operands; never two req_ready bits high at once.
- Backpressure: res_ready held low for 5 cycles after res_valid -> res_valid, res_data and res_id stable; req_ready=0 throughout; result transfers on the first edge with res_ready=1.
- Reset mid-RUN: assert rst at RUN step 4 -> outputs return to reset values immediately; no res_valid appears; the next job yields a correct, fresh sum with pointer restarted at 0.
- Wrap and withdrawal: grant requester 3, then only requester 1 valid -> requester 1 granted; with requester 1 valid but dropped before the grant, no grant occurs and the pointer is unchanged.

Source files
------------

// File: rtl/dp_pkg.sv
// -----------------------------------------------------------------------------
// dp_pkg
// Shared constants, the scheduler state encoding and the multiply-accumulate
// helper for the dot-product scheduler.
//   ELEMS : elements per vector
//   EW    : element width in bits
//   ACCW  : accumulator / result width
//   VW    : width of one packed operand vector (ELEMS*EW)
//   KW    : width of the element step counter
//   PW    : width of one element product
// -----------------------------------------------------------------------------
package dp_pkg;

   localparam int ELEMS = 8;
   localparam int EW    = 16;
   localparam int ACCW  = 36;
   localparam int VW    = ELEMS * EW;
   localparam int KW    = $clog2(ELEMS);
   localparam int PW    = 2 * EW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One MAC step: unsigned EW x EW product, zero-extended into the
   // accumulator. 8 * (2^16-1)^2 fits in 35 bits, so the sum never wraps.
   function automatic logic [ACCW-1:0] mac_step(input logic [ACCW-1:0] acc,
                                                input logic [EW-1:0]   a,
                                                input logic [EW-1:0]   b);
      logic [PW-1:0] prod;
      prod = a * b;
      return acc + {{(ACCW-PW){1'b0}}, prod};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant selection. Searches req starting at
// index ptr, moving upward with wrap-around, and grants the first set bit.
// The pointer register itself lives in the caller.
//   req       : in  NREQ  request vector
//   ptr       : in  IDW   index searched first
//   enable    : in  1     when low, no grant is produced
//   grant     : out NREQ  one-hot grant (all-zero if none)
//   grant_idx : out IDW   binary index of the granted bit (0 if none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);

   logic found;
   int   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < NREQ; i++) begin
         // Candidate i places after the pointer, wrapped into 0..NREQ-1.
         idx = (int'(ptr) + i) % NREQ;
         if (enable && !found && req[idx]) begin
            found          = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/dot_product_scheduler.sv
// -----------------------------------------------------------------------------
// dot_product_scheduler
// Shares one serial 16-bit multiply-accumulate engine between NREQ requesters.
// A job is one 8-element unsigned inner product; the result is returned with
// the ID of the requester that issued it.
//
// Ports:
//   clk        : in  1             system clock, rising edge
//   rst        : in  1             asynchronous reset, active-high
//   req_valid  : in  NREQ          per-requester job valid
//   req_ready  : out NREQ          per-requester accept, at most one bit high
//   req_a      : in  NREQ*VW       operand A vectors, requester r at [r*VW +: VW]
//   req_b      : in  NREQ*VW       operand B vectors, same packing
//   res_valid  : out 1             result valid
//   res_ready  : in  1             consumer accepts result
//   res_data   : out ACCW          inner product
//   res_id     : out IDW           requester that issued the job
//   busy       : out 1             high whenever the FSM is not IDLE
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A requester may drop req_valid before it is
// granted; it then simply loses its turn. res_valid, res_data and res_id stay
// stable from assertion until the transfer edge. req_ready is combinational
// from req_valid and is only ever non-zero in IDLE.
//
// Timing: the acceptance edge loads the operands, eight RUN edges perform one
// MAC each (the last one loads the result), and one DONE edge hands the result
// over, so back-to-back jobs complete every 10 cycles with res_ready high.
// -----------------------------------------------------------------------------
module dot_product_scheduler
   import dp_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*VW-1:0]   req_a,
   input  logic [NREQ*VW-1:0]   req_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ACCW-1:0]      res_data,
   output logic [IDW-1:0]       res_id,
   output logic                 busy
);

   state_t            state;
   state_t            state_nxt;

   logic [IDW-1:0]    ptr;        // requester searched first in IDLE
   logic [VW-1:0]     op_a;       // captured operands of the running job
   logic [VW-1:0]     op_b;
   logic [KW-1:0]     k;          // element index of the next MAC step
   logic [ACCW-1:0]   acc;
   logic [ACCW-1:0]   acc_nxt;
   logic [IDW-1:0]    job_id;     // requester of the running job

   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    grant_idx;
   logic              accept;
   logic              last_step;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .enable    (state == IDLE),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Sum after adding the current element pair.
   always_comb begin
      acc_nxt = mac_step(acc, op_a[k*EW +: EW], op_b[k*EW +: EW]);
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and combinational outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      req_ready = grant;           // arbiter is disabled outside IDLE
      accept    = |(req_valid & grant);
      busy      = (state != IDLE);
      last_step = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            last_step = (k == KW'(ELEMS - 1));
            if (last_step) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         k         <= '0;
         acc       <= '0;
         job_id    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  // Operands are copied so the requester may change its
                  // inputs while the job runs.
                  op_a   <= req_a[grant_idx*VW +: VW];
                  op_b   <= req_b[grant_idx*VW +: VW];
                  job_id <= grant_idx;
                  acc    <= '0;
                  k      <= '0;
                  // Explicit wrap keeps non-power-of-two NREQ correct.
                  if (grant_idx == IDW'(NREQ - 1)) begin
                     ptr <= '0;
                  end else begin
                     ptr <= grant_idx + 1'b1;
                  end
               end
            end
            RUN: begin
               acc <= acc_nxt;
               k   <= k + 1'b1;
               if (last_step) begin
                  res_data  <= acc_nxt;
                  res_id    <= job_id;
                  res_valid <= 1'b1;
               end
            end
            DONE: begin
               // res_data / res_id keep their values after the transfer.
               if (res_ready) begin
                  res_valid <= 1'b0;
               end
            end
            default: begin
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
